// File: rtl/cellrv32_cpu_cp_shifter_ext.sv
// ---------------------------------------------------------------------------
// cellrv32_cpu_cp_shifter_ext
// Shift/rotate co-processor for the CELLRV32 ALU: SLL/SRL/SRA, ROL/ROR and the
// RV64 word forms. STRIDE bits are shifted per cycle, so STRIDE = 1 is a
// bit-serial unit and STRIDE = XLEN is a single-step barrel shifter.
// ---------------------------------------------------------------------------
package cellrv32_package;

    // Main CPU control bus; this unit only looks at the trap/abort flag.
    typedef struct packed {
        logic cpu_trap;
    } ctrl_bus_t;

    // Number of index bits needed to address n positions (ceil(log2(n))).
    function automatic int index_size_f(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

module cellrv32_cpu_cp_shifter_ext
    import cellrv32_package::*;
#(
    parameter int XLEN   = 32,
    parameter int STRIDE = 1
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    input  ctrl_bus_t                      ctrl_i,
    input  logic                           start_i,
    input  logic [2:0]                     op_i,
    input  logic                           word_i,
    input  logic [XLEN-1:0]                rs1_i,
    input  logic [index_size_f(XLEN)-1:0]  shamt_i,
    output logic [XLEN-1:0]                res_o,
    output logic                           valid_o,
    output logic                           busy_o
);

    localparam int AW = index_size_f(XLEN);
    // One extra bit so the remaining count can hold XLEN without wrapping.
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_SLL = 3'b000,
        OP_SRL = 3'b001,
        OP_SRA = 3'b010,
        OP_ROL = 3'b011,
        OP_ROR = 3'b100
    } shift_op_t;

    state_t            state_q, state_d;
    shift_op_t         op_q;
    shift_op_t         op_dec;
    logic              word_q;
    logic [XLEN-1:0]   data_q;
    logic [CW-1:0]     cnt_q;     // shift bits still to apply

    logic              word_mode;
    logic [CW-1:0]     amt_eff;
    logic [XLEN-1:0]   cap_data;
    logic [CW-1:0]     step_amt;
    logic [XLEN-1:0]   step_res;
    logic [31:0]       lo;
    logic [XLEN-1:0]   res_full;

    // Decode the requested operation and the effective shift amount.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        op_dec    = OP_SLL;
        word_mode = (XLEN == 64) && word_i;
        amt_eff   = word_mode ? CW'(shamt_i[4:0]) : CW'(shamt_i);
        case (op_i)
            3'b001:  op_dec = OP_SRL;
            3'b010:  op_dec = OP_SRA;
            3'b011:  op_dec = OP_ROL;
            3'b100:  op_dec = OP_ROR;
            default: op_dec = OP_SLL;
        endcase
        // Word ops keep only the low half; SRAW pre-extends bit 31 so the
        // full-width arithmetic shift fills with the word sign, SRLW zero-fills.
        cap_data = rs1_i;
        if (word_mode) begin
            if (op_dec == OP_SRA) begin
                cap_data = XLEN'($signed(rs1_i[31:0]));
            end else begin
                cap_data = XLEN'(rs1_i[31:0]);
            end
        end
    end

    // One iteration of the shifter: move by min(STRIDE, remaining) bits.
    always_comb begin
        step_amt = (cnt_q > CW'(STRIDE)) ? CW'(STRIDE) : cnt_q;
        lo       = data_q[31:0];
        step_res = data_q;
        case (op_q)
            OP_SRL:  step_res = data_q >> step_amt;
            OP_SRA:  step_res = $signed(data_q) >>> step_amt;
            OP_ROL: begin
                if (word_q) begin
                    step_res = XLEN'((lo << step_amt) | (lo >> (CW'(32) - step_amt)));
                end else begin
                    step_res = (data_q << step_amt) | (data_q >> (CW'(XLEN) - step_amt));
                end
            end
            OP_ROR: begin
                if (word_q) begin
                    step_res = XLEN'((lo >> step_amt) | (lo << (CW'(32) - step_amt)));
                end else begin
                    step_res = (data_q >> step_amt) | (data_q << (CW'(XLEN) - step_amt));
                end
            end
            default: step_res = data_q << step_amt;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q <= state_d;
        end
    end

    // FSM next-state logic; a trap always wins and returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && !ctrl_i.cpu_trap) begin
                    state_d = (amt_eff == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (ctrl_i.cpu_trap) begin
                    state_d = S_IDLE;
                end else if (cnt_q == step_amt) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Operand capture on start, then iterate while running.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            op_q   <= OP_SLL;
            word_q <= 1'b0;
            data_q <= '0;
            cnt_q  <= '0;
        end else if (state_q == S_IDLE) begin
            if (start_i && !ctrl_i.cpu_trap) begin
                op_q   <= op_dec;
                word_q <= word_mode;
                data_q <= cap_data;
                cnt_q  <= amt_eff;
            end
        end else if ((state_q == S_RUN) && !ctrl_i.cpu_trap) begin
            data_q <= step_res;
            cnt_q  <= cnt_q - step_amt;
        end
    end

    // Result gating: word results are sign-extended from bit 31.
    always_comb begin
        res_full = word_q ? XLEN'($signed(data_q[31:0])) : data_q;
        valid_o  = (state_q == S_DONE);
        busy_o   = (state_q != S_IDLE);
        res_o    = valid_o ? res_full : '0;
    end

endmodule

// File: tb/tb_cellrv32_cpu_cp_shifter_ext.sv
// ---------------------------------------------------------------------------
// Bench for cellrv32_cpu_cp_shifter_ext: four instances with different
// XLEN/STRIDE share the operand inputs; each has its own start line.
// ---------------------------------------------------------------------------
module tb_cellrv32_cpu_cp_shifter_ext;
    import cellrv32_package::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        trap = 1'b0;
    logic [3:0]  start = '0;
    logic [2:0]  op = '0;
    logic        w = 1'b0;
    logic [63:0] rs1 = '0;
    logic [5:0]  shamt = '0;
    ctrl_bus_t   ctrl;
    wire  [3:0]  valid;
    wire  [3:0]  busy;
    logic [31:0] r0, r1, r2;
    logic [63:0] r3;
    logic [63:0] res [4];

    int total = 0;
    int bad   = 0;

    localparam int STRIDE_OF [4] = '{1, 4, 32, 8};
    localparam int XLEN_OF   [4] = '{32, 32, 32, 64};

    assign ctrl   = '{cpu_trap: trap};
    assign res[0] = {32'h0, r0};
    assign res[1] = {32'h0, r1};
    assign res[2] = {32'h0, r2};
    assign res[3] = r3;

    always #5 clk = ~clk;

    cellrv32_cpu_cp_shifter_ext #(.XLEN(32), .STRIDE(1)) u_d0 (
        .clk_i(clk), .rstn_i(rstn), .ctrl_i(ctrl), .start_i(start[0]), .op_i(op),
        .word_i(w), .rs1_i(rs1[31:0]), .shamt_i(shamt[4:0]),
        .res_o(r0), .valid_o(valid[0]), .busy_o(busy[0]));
    cellrv32_cpu_cp_shifter_ext #(.XLEN(32), .STRIDE(4)) u_d1 (
        .clk_i(clk), .rstn_i(rstn), .ctrl_i(ctrl), .start_i(start[1]), .op_i(op),
        .word_i(w), .rs1_i(rs1[31:0]), .shamt_i(shamt[4:0]),
        .res_o(r1), .valid_o(valid[1]), .busy_o(busy[1]));
    cellrv32_cpu_cp_shifter_ext #(.XLEN(32), .STRIDE(32)) u_d2 (
        .clk_i(clk), .rstn_i(rstn), .ctrl_i(ctrl), .start_i(start[2]), .op_i(op),
        .word_i(w), .rs1_i(rs1[31:0]), .shamt_i(shamt[4:0]),
        .res_o(r2), .valid_o(valid[2]), .busy_o(busy[2]));
    cellrv32_cpu_cp_shifter_ext #(.XLEN(64), .STRIDE(8)) u_d3 (
        .clk_i(clk), .rstn_i(rstn), .ctrl_i(ctrl), .start_i(start[3]), .op_i(op),
        .word_i(w), .rs1_i(rs1), .shamt_i(shamt),
        .res_o(r3), .valid_o(valid[3]), .busy_o(busy[3]));

    typedef struct {
        int          d;
        logic [2:0]  op;
        logic        w;
        logic [63:0] a;
        logic [5:0]  sh;
        logic [63:0] er;
        int          el;
    } vec_t;

    typedef struct {
        int          d;
        logic [63:0] er;
        int          el;
    } exp_t;

    vec_t vt [$];
    exp_t sb [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bit-by-bit reference: output bit i takes its source bit directly.
    function automatic logic [63:0] ref_res(input int xl, input logic [2:0] o, input logic wf,
                                            input logic [63:0] a, input logic [5:0] sh,
                                            output int s);
        int          n;
        logic [63:0] r;
        logic        wm;
        wm = (xl == 64) && wf;
        n  = wm ? 32 : xl;
        s  = (xl == 32 || wm) ? int'(sh[4:0]) : int'(sh);
        r  = '0;
        for (int i = 0; i < n; i++) begin
            case (o)
                3'd1:    r[i] = (i + s < n) ? a[i+s] : 1'b0;
                3'd2:    r[i] = (i + s < n) ? a[i+s] : a[n-1];
                3'd3:    r[i] = a[(i - s + n) % n];
                3'd4:    r[i] = a[(i + s) % n];
                default: r[i] = (i >= s) ? a[i-s] : 1'b0;
            endcase
        end
        if (wm) begin
            for (int i = 32; i < 64; i++) r[i] = r[31];
        end
        return r;
    endfunction

    // Watch DUT d from cycle first_cyc until its valid pulse, then score it.
    task automatic watch(input int d, input int first_cyc);
        int   cyc;
        logic got;
        exp_t e;
        cyc = first_cyc;
        got = 1'b0;
        while (!got && cyc <= 200) begin
            check("busy_run", busy[d], 1'b1);
            if (valid[d]) begin
                got = 1'b1;
                check("sb_nonempty", (sb.size() != 0), 1'b1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("latency", cyc, e.el);
                    check("result", res[d], e.er);
                end
            end else begin
                check("res_gated", res[d], 64'h0);
                @(negedge clk);
                cyc++;
            end
        end
        check("no_timeout", got, 1'b1);
        @(negedge clk);
        check("valid_end", valid[d], 1'b0);
        check("busy_end", busy[d], 1'b0);
    endtask

    task automatic run_vec(input vec_t v);
        sb.push_back('{v.d, v.er, v.el});
        @(negedge clk);
        op = v.op; w = v.w; rs1 = v.a; shamt = v.sh;
        start[v.d] = 1'b1;
        @(negedge clk);
        start = '0;
        // Scramble inputs: the captured operands must be used.
        op = 3'($urandom); w = 1'($urandom); rs1 = {$urandom, $urandom}; shamt = 6'($urandom);
        watch(v.d, 1);
    endtask

    task automatic count_stray(input int d, input int cycles, input string name);
        int hits;
        hits = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (valid[d] || busy[d]) hits++;
        end
        check(name, hits, 0);
    endtask

    initial begin
        vec_t v;
        int   s;

        // Table: d, op, word, rs1, shamt, expected result, expected latency
        vt.push_back('{0, 3'd0, 1'b0, 64'h1,                   6'd31, 64'h80000000,          32});
        vt.push_back('{0, 3'd1, 1'b0, 64'h80000000,            6'd7,  64'h01000000,          8});
        vt.push_back('{0, 3'd3, 1'b0, 64'h80000001,            6'd1,  64'h00000003,          2});
        vt.push_back('{0, 3'd2, 1'b0, 64'h80000000,            6'd0,  64'h80000000,          1});
        vt.push_back('{0, 3'd5, 1'b0, 64'h3,                   6'd2,  64'h0000000C,          3});
        vt.push_back('{1, 3'd2, 1'b0, 64'h80000000,            6'd7,  64'hFF000000,          3});
        vt.push_back('{1, 3'd1, 1'b0, 64'h80000000,            6'd7,  64'h01000000,          3});
        vt.push_back('{1, 3'd4, 1'b0, 64'h12345678,            6'd8,  64'h78123456,          3});
        vt.push_back('{1, 3'd0, 1'b0, 64'hFFFFFFFF,            6'd31, 64'h80000000,          9});
        vt.push_back('{2, 3'd4, 1'b0, 64'hF1,                  6'd4,  64'h1000000F,          2});
        vt.push_back('{2, 3'd4, 1'b0, 64'hF1,                  6'd0,  64'hF1,                1});
        vt.push_back('{2, 3'd2, 1'b0, 64'h80000000,            6'd31, 64'hFFFFFFFF,          2});
        vt.push_back('{2, 3'd2, 1'b0, 64'h7FFFFFFF,            6'd31, 64'h0,                 2});
        vt.push_back('{2, 3'd0, 1'b1, 64'h1,                   6'd31, 64'h80000000,          2});
        vt.push_back('{3, 3'd1, 1'b1, 64'hFFFFFFFF_80000000,   6'h21, 64'h00000000_40000000, 2});
        vt.push_back('{3, 3'd0, 1'b1, 64'h1,                   6'd31, 64'hFFFFFFFF_80000000, 5});
        vt.push_back('{3, 3'd4, 1'b1, 64'h1,                   6'd1,  64'hFFFFFFFF_80000000, 2});
        vt.push_back('{3, 3'd2, 1'b1, 64'h00000000_80000000,   6'd4,  64'hFFFFFFFF_F8000000, 2});
        vt.push_back('{3, 3'd3, 1'b1, 64'hABCDEF01_80000001,   6'd4,  64'h00000000_00000018, 2});
        vt.push_back('{3, 3'd1, 1'b1, 64'h12345678_9ABCDEF0,   6'h20, 64'hFFFFFFFF_9ABCDEF0, 1});
        vt.push_back('{3, 3'd2, 1'b0, 64'h80000000_00000000,   6'd63, 64'hFFFFFFFF_FFFFFFFF, 9});
        vt.push_back('{3, 3'd4, 1'b0, 64'h1,                   6'd63, 64'h2,                 9});
        vt.push_back('{3, 3'd0, 1'b0, 64'h1,                   6'd40, 64'h00000100_00000000, 6});

        // Reset state
        #12;
        for (int d = 0; d < 4; d++) begin
            check("rst_valid", valid[d], 1'b0);
            check("rst_busy", busy[d], 1'b0);
            check("rst_res", res[d], 64'h0);
        end
        @(negedge clk);
        rstn = 1'b1;

        foreach (vt[i]) run_vec(vt[i]);

        // Random vectors scored against the bit-level reference
        for (int i = 0; i < 16; i++) begin
            v.d  = i % 4;
            v.op = 3'($urandom_range(0, 7));
            v.w  = 1'($urandom);
            v.a  = {$urandom, $urandom};
            v.sh = 6'($urandom);
            v.er = ref_res(XLEN_OF[v.d], v.op, v.w, v.a, v.sh, s);
            v.el = 1 + (s + STRIDE_OF[v.d] - 1) / STRIDE_OF[v.d];
            run_vec(v);
        end

        // Abort: trap in cycle 5 of a 31-bit serial shift, restart in cycle 6
        @(negedge clk);
        op = 3'd0; w = 1'b0; rs1 = 64'h1; shamt = 6'd31; start[0] = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = '0;
            check("abort_busy", busy[0], 1'b1);
            check("abort_valid", valid[0], 1'b0);
            if (c == 5) trap = 1'b1;
        end
        @(negedge clk);
        trap = 1'b0;
        check("abort_idle_busy", busy[0], 1'b0);
        check("abort_idle_valid", valid[0], 1'b0);
        sb.push_back('{0, 64'h6, 2});
        op = 3'd0; rs1 = 64'h3; shamt = 6'd1; start[0] = 1'b1;
        @(negedge clk);
        start = '0;
        watch(0, 1);
        count_stray(0, 30, "abort_no_late_valid");

        // Trap in IDLE drops a simultaneous start
        @(negedge clk);
        op = 3'd0; rs1 = 64'h1; shamt = 6'd4; start[2] = 1'b1; trap = 1'b1;
        @(negedge clk);
        start = '0; trap = 1'b0;
        check("idle_trap_busy", busy[2], 1'b0);
        count_stray(2, 4, "idle_trap_no_valid");

        // Start pulsed in cycle 3 of a running shift is ignored
        sb.push_back('{1, 64'h80000000, 9});
        @(negedge clk);
        op = 3'd0; w = 1'b0; rs1 = 64'h1; shamt = 6'd31; start[1] = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start = '0;
            check("ign_busy", busy[1], 1'b1);
            if (c == 3) begin
                op = 3'd1; rs1 = 64'hFFFFFFFF; shamt = 6'd1; start[1] = 1'b1;
            end
        end
        @(negedge clk);
        start = '0;
        watch(1, 4);
        count_stray(1, 12, "ign_no_second_result");

        // Asynchronous reset mid-operation
        @(negedge clk);
        op = 3'd0; rs1 = 64'h1; shamt = 6'd31; start[0] = 1'b1;
        @(negedge clk);
        start = '0;
        @(negedge clk);
        #2 rstn = 1'b0;
        #1 check("arst_busy", busy[0], 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        count_stray(0, 35, "arst_no_valid");

        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cellrv32_cpu_cp_shifter_ext.md
# cellrv32_cpu_cp_shifter_ext

Parametrised shift/rotate co-processor for the CELLRV32 CPU ALU. It implements base-ISA shifts (SLL/SRL/SRA), Zbb rotates (ROL/ROR) and RV64 word variants (SLLW/SRLW/SRAW/ROLW/RORW). A configurable stride sets the trade-off between a bit-serial unit and a single-step barrel shifter. It sits beside the other ALU co-processors, and its gated result is OR-ed onto the shared co-processor result bus.

## Interface
Parameters:
- XLEN, 32: data path width; only 32 or 64 are legal.
- STRIDE, 1: bits shifted per iteration. Must be a power of two with 1 ≤ STRIDE ≤ XLEN. STRIDE = XLEN gives single-step barrel behaviour.

Ports:
- clk_i  in  1  global clock, rising edge.
- rstn_i  in  1  global reset; asynchronous, active-low.
- ctrl_i  in  ctrl_bus_t  main control bus; only ctrl_i.cpu_trap is used (abort).
- start_i  in  1  single-cycle trigger; sampled only in IDLE.
- op_i  in  3  operation, sampled with start_i: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR. Codes 101–111 are treated as SLL.
- word_i  in  1  32-bit word operation; legal only when XLEN = 64 and ignored when XLEN = 32.
- rs1_i  in  XLEN  operand.
- shamt_i  in  index_size_f(XLEN)  shift amount.
- res_o  out  XLEN  result; all-zero except in the valid cycle.
- valid_o  out  1  one-cycle result strobe.
- busy_o  out  1  high in RUN and DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- Reset: state IDLE; res_o = 0, valid_o = 0, busy_o = 0; all internal registers cleared.
- IDLE with start_i = 1:
  - Capture op, word flag, operand and effective amount s into registers. Later changes on the inputs have no effect.
  - Effective amount: s = shamt_i, or s = shamt_i[4:0] when word mode is active.
  - Load iteration counter N = ceil(s / STRIDE).
  - If N = 0, go to DONE; otherwise go to RUN.
- RUN: each cycle applies a step of min(STRIDE, remaining) bits and decrements the counter. When the counter reaches 0, go to DONE.
- DONE: drive valid_o = 1 and res_o = result for exactly one cycle, then return to IDLE.
- Semantics, non-word (XLEN bits):
  - SLL fills with zeros.
  - SRL fills with zeros.
  - SRA fills with the captured rs1[XLEN-1].
  - ROL/ROR rotate over XLEN bits.
- Semantics, word mode: operate on rs1[31:0] only.
  - SRAW fills with rs1[31].
  - ROLW/RORW rotate within 32 bits.
  - The final 32-bit value is sign-extended from bit 31 to 64 bits for every word op.
- start_i asserted in RUN or DONE is ignored; there is no queueing.
- Abort: ctrl_i.cpu_trap = 1 in RUN or DONE forces IDLE on the next edge, with no valid_o pulse.
  - cpu_trap in IDLE has priority over start_i: the start is dropped.
- Arithmetic: the counter is index_size_f(XLEN)+1 bits wide and never wraps. The step amount never exceeds the remaining count, so the total shift equals s exactly.

## Timing
- start_i is in cycle 0. valid_o rises in cycle 1 + N and lasts one cycle.
- Example latencies:
  - STRIDE = 1: latency 1 + s.
  - STRIDE = XLEN: latency 2 for s > 0, 1 for s = 0.
- busy_o is high from cycle 1 through cycle 1 + N inclusive.
- The earliest next start is in cycle 2 + N, i.e. the cycle after valid_o.
- res_o is combinationally gated by the DONE state, and zero in all other cycles.
- Asynchronous reset mid-operation clears everything immediately; no valid_o follows.

## Test plan
- SLL, XLEN = 32, STRIDE = 1, rs1 = 0x00000001, shamt = 31 → valid_o only in cycle 32, res_o = 0x80000000; res_o = 0 in every other cycle; busy_o high in cycles 1–32.
- SRA, STRIDE = 4, rs1 = 0x80000000, shamt = 7 → N = 2, valid_o in cycle 3, res_o = 0xFF000000. Repeat with SRL → 0x01000000.
- ROR, STRIDE = XLEN, rs1 = 0x000000F1, shamt = 4 → valid_o in cycle 2, res_o = 0x1000000F. Repeat with shamt = 0 → valid_o in cycle 1, res_o = 0x000000F1.
- XLEN = 64, word_i = 1:
  - SRLW, rs1 = 0xFFFFFFFF_80000000, shamt = 0x21 → res_o = 0x00000000_40000000.
  - SLLW, rs1 = 0x1, shamt = 31 → res_o = 0xFFFFFFFF_80000000.
  - RORW, rs1 = 0x00000000_00000001, shamt = 1 → res_o = 0xFFFFFFFF_80000000.
- Abort, STRIDE = 1, shamt = 31: cpu_trap = 1 in cycle 5 → busy_o low from cycle 6, no valid_o ever. A new start in cycle 6 (SLL 0x3, shamt 1) → res_o = 0x00000006 in cycle 2 after that start.
- start_i pulsed in cycle 3 of a running shift with different operands → ignored; the original result is delivered unchanged at its scheduled cycle.
